// File: rtl/count_frame_streamer_pkg.sv
// Shared definitions for the count frame streamer.
//   stream_state_e : frame sequencer states (IDLE, HDR, CH)
//   idx_width()    : channel index width, never less than one bit
package counter_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        CH   = 2'd2
    } stream_state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/count_frame_streamer_snapshot_bank.sv
// Snapshot register bank: latches every channel of a flat counter bus in the
// same clock cycle and exposes one entry through a read-index mux.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (clears the bank)
//   capture      : load all channels from ch_count_in this cycle
//   ch_count_in  : flat bus, channel k at [k*CNT_W +: CNT_W]
//   rd_idx       : channel to present on rd_data
//   rd_data      : combinational read of snap[rd_idx]
module count_snapshot_bank
    import counter_stream_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = idx_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    capture,
    input  logic [NUM_CH*CNT_W-1:0] ch_count_in,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [CNT_W-1:0]        rd_data
);

    logic [CNT_W-1:0] snap [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < NUM_CH; k++) snap[k] <= ch_count_in[k*CNT_W +: CNT_W];
        end
    end

    // Guard keeps non-power-of-two channel counts from reading past the array.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < NUM_CH) rd_data = snap[rd_idx];
    end

endmodule

// File: rtl/count_frame_streamer.sv
// Count frame streamer: captures NUM_CH counters at once and streams them as
// a frame (header word = sequence number, then one word per channel) over a
// valid/ready handshake.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   ch_count_in        : flat counter bus, channel k at [k*CNT_W +: CNT_W]
//   snap_req           : single-cycle software capture request
//   stop_step, auto_en : rising edge of stop_step triggers when auto_en=1
//   out_data/valid/last: stream word, valid, final-channel marker
//   out_ready          : downstream accept
//   busy               : frame in progress
//   overrun, clr_ovr   : sticky lost-trigger flag and its clear
//   seq_num            : current frame sequence number
module count_frame_streamer
    import counter_stream_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int CNT_W  = 32,
    parameter int SEQ_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*CNT_W-1:0] ch_count_in,
    input  logic                    snap_req,
    input  logic                    stop_step,
    input  logic                    auto_en,
    output logic [CNT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    clr_ovr,
    output logic [SEQ_W-1:0]        seq_num
);

    localparam int               IDX_W    = idx_width(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    stream_state_e    state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [SEQ_W-1:0] seq_nxt;
    logic [CNT_W-1:0] snap_word, data_nxt;
    logic             last_nxt;
    logic             stop_d, trig, hs, last_hs, capture, ovr_set;

    assign trig      = snap_req | (auto_en & stop_step & ~stop_d);
    assign busy      = (state != IDLE);
    assign out_valid = busy;
    assign hs        = out_valid & out_ready;
    assign last_hs   = hs && (state == CH) && (idx == LAST_IDX);
    // A trigger landing on the final handshake starts the next frame instead
    // of being counted as lost.
    assign ovr_set   = trig & busy & ~last_hs;

    // The bank is addressed with the next index so out_data can be registered
    // one cycle ahead of the word being presented.
    count_snapshot_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .capture     (capture),
        .ch_count_in (ch_count_in),
        .rd_idx      (idx_nxt),
        .rd_data     (snap_word)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            seq_num  <= '0;
            stop_d   <= 1'b0;
            overrun  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            seq_num  <= seq_nxt;
            stop_d   <= stop_step;
            overrun  <= ovr_set | (overrun & ~clr_ovr);
            out_data <= data_nxt;
            out_last <= last_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        seq_nxt   = seq_num;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nxt = HDR;
                    capture   = 1'b1;
                end
            end
            HDR: begin
                if (hs) begin
                    state_nxt = CH;
                    idx_nxt   = '0;
                end
            end
            CH: begin
                if (hs) begin
                    if (idx == LAST_IDX) begin
                        seq_nxt = seq_num + 1'b1;
                        idx_nxt = '0;
                        if (trig) begin
                            state_nxt = HDR;
                            capture   = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output word selection; with no handshake every input here is unchanged,
    // so data and last hold during a stall.
    always_comb begin
        data_nxt = '0;
        last_nxt = 1'b0;
        case (state_nxt)
            HDR: data_nxt = CNT_W'(seq_nxt);
            CH: begin
                data_nxt = snap_word;
                last_nxt = (idx_nxt == LAST_IDX);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_count_frame_streamer.sv
`timescale 1ns/1ps
module tb_count_frame_streamer;

    localparam int NUM_CH   = 32;
    localparam int CNT_W    = 32;
    localparam int SEQ_W    = 16;
    localparam int S_NUM_CH = 4;
    localparam int S_CNT_W  = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset = 1'b1;
    logic [NUM_CH*CNT_W-1:0] ch_count_in = '0;
    logic                    snap_req = 1'b0, stop_step = 1'b0, auto_en = 1'b0;
    logic                    out_ready = 1'b0, clr_ovr = 1'b0;
    logic [CNT_W-1:0]        out_data;
    logic                    out_valid, out_last, busy, overrun;
    logic [SEQ_W-1:0]        seq_num;

    count_frame_streamer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .reset(reset), .ch_count_in(ch_count_in), .snap_req(snap_req),
        .stop_step(stop_step), .auto_en(auto_en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr), .seq_num(seq_num)
    );

    // Small configuration instance
    logic [S_NUM_CH*S_CNT_W-1:0] s_ch = '0;
    logic                        s_snap = 1'b0, s_ready = 1'b1;
    logic [S_CNT_W-1:0]          s_data;
    logic                        s_valid, s_last, s_busy, s_ovr;
    logic [SEQ_W-1:0]            s_seq;

    count_frame_streamer #(.NUM_CH(S_NUM_CH), .CNT_W(S_CNT_W), .SEQ_W(SEQ_W)) dut_small (
        .clk(clk), .reset(reset), .ch_count_in(s_ch), .snap_req(s_snap),
        .stop_step(1'b0), .auto_en(1'b0), .out_data(s_data),
        .out_valid(s_valid), .out_ready(s_ready), .out_last(s_last),
        .busy(s_busy), .overrun(s_ovr), .clr_ovr(1'b0), .seq_num(s_seq)
    );

    typedef struct {
        logic [CNT_W-1:0] data;
        logic             last;
    } word_t;

    word_t            exp_q[$];
    int               n_checks = 0, n_fail = 0;
    int               n_words = 0, n_frames_out = 0;
    logic [SEQ_W-1:0] m_seq = '0;
    logic             m_ovr = 1'b0, m_stop_d = 1'b0;
    logic             stall_prev = 1'b0, prev_last = 1'b0;
    logic [CNT_W-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor: at each falling edge compare what the DUT
    // shows, retire the word being accepted, then predict the coming edge.
    always @(negedge clk) begin : model
        word_t e, w;
        logic  trig, set;
        if (reset) begin
            exp_q.delete();
            m_seq      = '0;
            m_ovr      = 1'b0;
            m_stop_d   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("busy", busy, exp_q.size() != 0);
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("seq_num", seq_num, m_seq);
            chk("overrun", overrun, m_ovr);
            if (out_valid) begin
                if (stall_prev) begin
                    chk("stall_data", out_data, prev_data);
                    chk("stall_last", out_last, prev_last);
                end
                if (out_ready) begin
                    n_words++;
                    if (out_last) n_frames_out++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", out_data, e.data);
                        chk("word_last", out_last, e.last);
                        if (e.last) m_seq = m_seq + 1'b1;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;

            trig = snap_req | (auto_en & stop_step & ~m_stop_d);
            set  = 1'b0;
            if (trig) begin
                if (exp_q.size() == 0) begin
                    w.data = CNT_W'(m_seq);
                    w.last = 1'b0;
                    exp_q.push_back(w);
                    for (int k = 0; k < NUM_CH; k++) begin
                        w.data = ch_count_in[k*CNT_W +: CNT_W];
                        w.last = (k == NUM_CH - 1);
                        exp_q.push_back(w);
                    end
                end else begin
                    set = 1'b1;
                end
            end
            m_ovr    = set ? 1'b1 : (clr_ovr ? 1'b0 : m_ovr);
            m_stop_d = stop_step;
        end
    end

    // Stimulus helpers: every task starts and ends 1ns after a rising edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_ch_base(input logic [CNT_W-1:0] base);
        for (int k = 0; k < NUM_CH; k++) ch_count_in[k*CNT_W +: CNT_W] = base + CNT_W'(k);
    endtask

    task automatic pulse_snap();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while ((busy || exp_q.size() != 0) && c < 1000) begin
            tick();
            c++;
        end
        chk({name, "_idle_timeout"}, c >= 1000, 0);
    endtask

    task automatic async_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq", seq_num, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovr", overrun, 0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               w0, f0, got, found;
        logic             any_busy;
        logic [SEQ_W-1:0] seq0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovr", overrun, 0);
        chk("reset_seq", seq_num, 0);
        chk("reset_data", out_data, 0);
        chk("reset_last", out_last, 0);
        reset = 1'b0;
        tick();

        // Scenario 1: straight frame
        out_ready = 1'b1;
        set_ch_base(32'h1000);
        w0 = n_words;
        pulse_snap();
        wait_idle("s1");
        chk("s1_words", n_words - w0, 33);
        chk("s1_seq", seq_num, 1);
        chk("s1_busy", busy, 0);

        // Scenario 2: stalls and moving counters after capture
        set_ch_base(32'h1000);
        w0 = n_words;
        pulse_snap();
        for (int c = 0; c < 400 && (busy || exp_q.size() != 0); c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            for (int k = 0; k < NUM_CH; k++)
                ch_count_in[k*CNT_W +: CNT_W] = ch_count_in[k*CNT_W +: CNT_W] + 1;
            tick();
        end
        out_ready = 1'b1;
        wait_idle("s2");
        chk("s2_words", n_words - w0, 33);

        // Scenario 3: auto trigger on stop_step edge
        auto_en   = 1'b1;
        f0        = n_frames_out;
        stop_step = 1'b1;
        repeat (100) tick();
        wait_idle("s3");
        chk("s3_frames", n_frames_out - f0, 1);
        stop_step = 1'b0;
        tick();
        auto_en   = 1'b0;
        stop_step = 1'b1;
        any_busy  = 1'b0;
        repeat (40) begin
            tick();
            any_busy |= busy;
        end
        chk("s3_noauto_busy", any_busy, 0);
        chk("s3_noauto_frames", n_frames_out - f0, 1);
        stop_step = 1'b0;
        tick();

        // Scenario 4: lost trigger, clear, clear racing a new loss
        set_ch_base(32'h3000);
        pulse_snap();
        repeat (4) tick();
        set_ch_base(32'h5000);
        pulse_snap();
        chk("s4_ovr_set", overrun, 1);
        wait_idle("s4a");
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("s4_ovr_clr", overrun, 0);
        pulse_snap();
        repeat (4) tick();
        snap_req = 1'b1;
        clr_ovr  = 1'b1;
        tick();
        snap_req = 1'b0;
        clr_ovr  = 1'b0;
        chk("s4_ovr_keep", overrun, 1);
        wait_idle("s4b");
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;

        // Scenario 5: trigger on the final handshake
        seq0 = m_seq;
        pulse_snap();
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (out_valid && out_last) found = 1;
            else tick();
        end
        chk("s5_found_last", found, 1);
        set_ch_base(32'h2000);
        pulse_snap();
        chk("s5_valid", out_valid, 1);
        chk("s5_hdr", out_data, CNT_W'(seq0 + 1'b1));
        chk("s5_ovr", overrun, 0);
        wait_idle("s5");

        // Scenario 6: reset mid-frame, then a fresh frame from seq 0
        pulse_snap();
        repeat (9) tick();
        async_reset();
        pulse_snap();
        chk("s6_valid", out_valid, 1);
        chk("s6_hdr", out_data, 0);
        wait_idle("s6");

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            snap_req  = ($urandom_range(0, 49) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_ovr   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 19) == 0) stop_step = ~stop_step;
            for (int k = 0; k < NUM_CH; k++) ch_count_in[k*CNT_W +: CNT_W] = $urandom;
            tick();
        end
        snap_req  = 1'b0;
        auto_en   = 1'b0;
        clr_ovr   = 1'b0;
        out_ready = 1'b1;
        wait_idle("drain");

        // Small configuration: NUM_CH=4, CNT_W=24 gives a 5-word frame
        for (int k = 0; k < S_NUM_CH; k++) s_ch[k*S_CNT_W +: S_CNT_W] = S_CNT_W'(32'h1000 + k);
        s_snap = 1'b1;
        tick();
        s_snap = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (s_valid && s_ready) begin
                chk("small_data", s_data, (got == 0) ? 0 : (32'h1000 + got - 1));
                chk("small_last", s_last, got == 4);
                got++;
            end
            tick();
        end
        chk("small_words", got, 5);
        chk("small_busy", s_busy, 0);
        chk("small_seq", s_seq, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
